// File: rtl/isqrt_pipe_n.sv
// Fully pipelined 32-bit integer square root, y = floor(sqrt(x)), fixed latency N_STAGES.
// Restoring digit-by-digit algorithm, 16/N_STAGES iterations per registered stage.
module isqrt_pipe_n #(
    parameter int N_STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    localparam int K = (N_STAGES > 0) ? (16 / N_STAGES) : 1;

    typedef struct packed {
        logic [31:0] bits;
        logic [17:0] rem;
        logic [15:0] root;
    } sq_state_t;

    if ((N_STAGES < 1) || (N_STAGES > 16) || ((16 % N_STAGES) != 0)) begin : g_bad_stages
        $error("isqrt_pipe_n: N_STAGES must be 1, 2, 4, 8 or 16");
    end

    // rem stays below 2^16 before each shift, so dropping its top two bits is lossless.
    function automatic sq_state_t sqrt_iters(input sq_state_t s);
        sq_state_t   v;
        logic [17:0] trial;
        v = s;
        for (int i = 0; i < K; i++) begin
            v.rem  = {v.rem[15:0], v.bits[31:30]};
            v.bits = {v.bits[29:0], 2'b00};
            trial  = {v.root, 2'b01};
            if (v.rem >= trial) begin
                v.rem  = v.rem - trial;
                v.root = {v.root[14:0], 1'b1};
            end else begin
                v.root = {v.root[14:0], 1'b0};
            end
        end
        return v;
    endfunction

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        logic      vld_in_s;
        sq_state_t st_in_s;
        sq_state_t st_nxt_s;
        logic      vld_r;
        sq_state_t st_r;

        if (g == 0) begin : g_first
            assign vld_in_s = x_vld;
            assign st_in_s  = {x, 18'd0, 16'd0};
        end else begin : g_next
            assign vld_in_s = g_stage[g-1].vld_r;
            assign st_in_s  = g_stage[g-1].st_r;
        end

        assign st_nxt_s = sqrt_iters(st_in_s);

        // Stage valid flag; clearing it is what discards operands in flight.
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_in_s;
            end
        end

        // Stage datapath; contents of an invalid stage are meaningless, so no reset.
        always_ff @(posedge clk) begin
            st_r <= st_nxt_s;
        end
    end

    // Final remainder and leftover operand bits are not part of the result.
    sq_state_t unused_tail_s;
    assign unused_tail_s = g_stage[N_STAGES-1].st_r;

    assign y_vld = g_stage[N_STAGES-1].vld_r;
    assign y     = g_stage[N_STAGES-1].st_r.root;

endmodule

// File: tb/tb_isqrt_pipe_n.sv
// Scoreboard bench for isqrt_pipe_n: one DUT per legal N_STAGES, all fed the same stream;
// per-DUT monitors check value, exact output cycle, reset discard and absence of spurious y_vld.
module tb_isqrt_pipe_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    int          cyc = 0;

    typedef struct {
        logic [15:0] y;
        int          p;
    } exp_t;

    exp_t     issued[$];
    int       rst_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    logic     fin_req = 1'b0;
    logic [4:0] fin_ack = 5'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // An operand issued in cycle p is lost if a reset cycle r satisfies p <= r < p+n.
    function automatic bit killed(input int p, input int n);
        foreach (rst_q[k]) begin
            if (rst_q[k] >= p && rst_q[k] < p + n) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        logic [63:0] r;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid - 1;
        end
        r = 64'(lo);
        return r[15:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] xv, input logic [15:0] ye, input logic r);
        @(negedge clk);
        rst   = r;
        x_vld = v;
        x     = xv;
        if (!r) rst_q.push_back(cyc);
        if (v) issued.push_back('{y: ye, p: cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 16'd0, 1'b1);
    endtask

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        localparam int N = 1 << gi;
        logic        y_vld_w;
        logic [15:0] y_w;

        isqrt_pipe_n #(.N_STAGES(N)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .x_vld (x_vld),
            .x     (x),
            .y_vld (y_vld_w),
            .y     (y_w)
        );

        initial begin
            int idx = 0;
            int pend;
            forever begin
                @(negedge clk);
                if (rst_q.size() > 0 && cyc > rst_q[0]) begin
                    if (cyc == rst_q[$] + 1) begin
                        n_cmp++;
                        if (y_vld_w !== 1'b0) begin
                            n_bad++;
                            $display("FAIL reset_state N=%0d cyc=%0d: y_vld=%b required 0", N, cyc, y_vld_w);
                        end
                    end
                    while (idx < issued.size() &&
                           (killed(issued[idx].p, N) || issued[idx].p + N < cyc)) begin
                        if (!killed(issued[idx].p, N)) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL missing_y N=%0d: no y_vld, required y=0x%0h at cyc %0d",
                                     N, issued[idx].y, issued[idx].p + N);
                        end
                        idx++;
                    end
                    if (y_vld_w === 1'b1) begin
                        n_cmp++;
                        if (idx < issued.size() && issued[idx].p + N == cyc) begin
                            if (y_w !== issued[idx].y) begin
                                n_bad++;
                                $display("FAIL y_value N=%0d cyc=%0d: got 0x%0h required 0x%0h",
                                         N, cyc, y_w, issued[idx].y);
                            end
                            idx++;
                        end else begin
                            n_bad++;
                            $display("FAIL spurious_y_vld N=%0d cyc=%0d: got y_vld=1 required 0", N, cyc);
                        end
                    end else if (y_vld_w !== 1'b0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL y_vld_unknown N=%0d cyc=%0d: got %b required 0/1", N, cyc, y_vld_w);
                    end
                end
                if (fin_req && !fin_ack[gi]) begin
                    pend = 0;
                    for (int k = idx; k < issued.size(); k++) begin
                        if (!killed(issued[k].p, N)) pend++;
                    end
                    n_cmp++;
                    if (pend != 0) begin
                        n_bad++;
                        $display("FAIL drain N=%0d: %0d results outstanding, required 0", N, pend);
                    end
                    fin_ack[gi] = 1'b1;
                end
            end
        end
    end

    initial begin
        int          nv;
        logic [31:0] xv;
        logic [31:0] k32;
        logic        v;

        rst   = 1'b0;
        x_vld = 1'b0;
        x     = 32'd0;
        drive(1'b0, 32'd0, 16'd0, 1'b0);
        drive(1'b0, 32'd0, 16'd0, 1'b0);
        idle(3);

        // Isolated operands
        drive(1'b1, 32'd0,  16'd0, 1'b1); idle(20);
        drive(1'b1, 32'd1,  16'd1, 1'b1); idle(20);
        drive(1'b1, 32'd15, 16'd3, 1'b1); idle(20);
        drive(1'b1, 32'd16, 16'd4, 1'b1); idle(20);

        // Extremes and k*k-1 values
        drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1);
        drive(1'b1, 32'hFFFE_0001, 16'hFFFF, 1'b1);
        drive(1'b1, 32'hFFFE_0000, 16'hFFFE, 1'b1);
        drive(1'b1, 32'd24,        16'd4,    1'b1);
        drive(1'b1, 32'd255,       16'd15,   1'b1);
        drive(1'b1, 32'd65535,     16'd255,  1'b1);
        idle(20);

        // Back-to-back i*i+i -> i
        for (int i = 0; i < 20; i++) drive(1'b1, 32'(i * i + i), 16'(i), 1'b1);
        idle(20);

        // Gapped pattern 1,0,1,1,0,0,1
        drive(1'b1, 32'd100,     16'd10,   1'b1);
        drive(1'b0, 32'd0,       16'd0,    1'b1);
        drive(1'b1, 32'd144,     16'd12,   1'b1);
        drive(1'b1, 32'd2,       16'd1,    1'b1);
        drive(1'b0, 32'd0,       16'd0,    1'b1);
        drive(1'b0, 32'd0,       16'd0,    1'b1);
        drive(1'b1, 32'd1000000, 16'd1000, 1'b1);
        idle(20);

        // Reset mid-flight: 81 issued in the reset cycle itself
        drive(1'b1, 32'd49, 16'd7, 1'b1);
        drive(1'b1, 32'd64, 16'd8, 1'b1);
        drive(1'b1, 32'd81, 16'd9, 1'b0);
        drive(1'b0, 32'd0,  16'd0, 1'b1);
        drive(1'b1, 32'd25, 16'd5, 1'b1);
        idle(20);

        // Random operands against the binary-search reference
        nv = 0;
        while (nv < 10000) begin
            v = ($urandom_range(0, 3) != 0);
            k32 = 32'($urandom_range(1, 65535));
            case ($urandom_range(0, 3))
                0: xv = $urandom;
                1: xv = 32'($urandom_range(0, 65535));
                2: xv = k32 * k32;
                default: xv = k32 * k32 - 32'd1;
            endcase
            drive(v, xv, ref_sqrt(xv), 1'b1);
            if (v) nv++;
        end
        idle(20);

        fin_req = 1'b1;
        for (int t = 0; t < 50 && !(&fin_ack); t++) @(negedge clk);
        if (!(&fin_ack)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL finish_timeout: ack=%b required 11111", fin_ack);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
